// File: rtl/rf_cmd_ctrl.sv
// Command decoder: turns UART byte frames into register-file writes/reads and pushes read data back to TX.
// Latency: RF strobe one cycle after the last frame byte; TX push one cycle after read data with FIFO space.
// Backpressure: holds captured read data while FIFO_FULL is high; RX bytes arriving mid-read are dropped.
module rf_cmd_ctrl #(
    parameter int ADDR_SIZE  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_SIZE-1:0]  RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_valid,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      TO_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    state_t                  state_q,   state_d;
    logic [ADDR_SIZE-1:0]    wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]    rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    wr_en_q,   wr_en_d;
    logic                    rd_en_q,   rd_en_d;
    logic                    tx_vld_q,  tx_vld_d;
    logic                    busy_q,    busy_d;

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            rf_addr_q <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rf_addr_q <= rf_addr_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_vld_q  <= tx_vld_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output decode; strobes default low so each is a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rf_addr_d = rf_addr_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    wr_addr_d = RX_P_DATA[ADDR_SIZE-1:0];
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_addr_d = wr_addr_q;
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_d = RX_P_DATA[ADDR_SIZE-1:0];
                    rd_en_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RF_RdData_valid) begin
                    rd_data_d = RF_RdData;
                    cnt_d     = '0;
                    state_d   = TX_SEND;
                end else if (cnt_q == TO_LAST) begin
                    // Register file never answered: drop the read silently.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_SEND: begin
                if (!FIFO_FULL) begin
                    tx_data_d = rd_data_q;
                    tx_vld_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign RF_WrEn    = wr_en_q;
    assign RF_RdEn    = rd_en_q;
    assign RF_Address = rf_addr_q;
    assign RF_WrData  = wr_data_q;
    assign TX_P_DATA  = tx_data_q;
    assign TX_D_VLD   = tx_vld_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Directed bench for rf_cmd_ctrl with a small register-file model answering reads one cycle after RF_RdEn.
module tb_rf_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic       RF_WrEn;
    logic       RF_RdEn;
    logic [3:0] RF_Address;
    logic [7:0] RF_WrData;
    logic [7:0] RF_RdData;
    logic       RF_RdData_valid;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       FIFO_FULL = 1'b0;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    int wr_cnt = 0;
    int rd_cnt = 0;
    int tx_cnt = 0;

    logic       model_rd_ok = 1'b1;
    logic [7:0] mem [16] = '{2: 8'h81, default: 8'h00};
    logic       rd_vld = 1'b0;
    logic [7:0] rd_dat = 8'h00;

    assign RF_RdData       = rd_dat;
    assign RF_RdData_valid = rd_vld;

    rf_cmd_ctrl #(.ADDR_SIZE(4), .DATA_WIDTH(8), .RD_TIMEOUT(8)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .RX_P_DATA       (RX_P_DATA),
        .RX_D_VLD        (RX_D_VLD),
        .RF_WrEn         (RF_WrEn),
        .RF_RdEn         (RF_RdEn),
        .RF_Address      (RF_Address),
        .RF_WrData       (RF_WrData),
        .RF_RdData       (RF_RdData),
        .RF_RdData_valid (RF_RdData_valid),
        .TX_P_DATA       (TX_P_DATA),
        .TX_D_VLD        (TX_D_VLD),
        .FIFO_FULL       (FIFO_FULL),
        .BUSY            (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Register-file model: synchronous write, read data valid the cycle after RF_RdEn.
    always @(posedge CLK) begin
        rd_vld <= RF_RdEn && model_rd_ok;
        rd_dat <= mem[RF_Address];
        if (RF_WrEn) mem[RF_Address] <= RF_WrData;
    end

    // Strobe counters and the write/read exclusivity check, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RF_WrEn)  wr_cnt++;
        if (RF_RdEn)  rd_cnt++;
        if (TX_D_VLD) tx_cnt++;
        if (RST) check("wr_rd_exclusive", {31'd0, RF_WrEn & RF_RdEn}, 32'd0);
    end

    // Caller sits just after a rising edge; byte is sampled at the next edge, back-to-back calls give no gap.
    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        cycles(2);
        RST = 1'b1;
        cycles(1);
    endtask

    initial begin
        int w0, t0, r0, n;
        bit seen;

        // Reset state
        #12;
        check("rst_wren",  {31'd0, RF_WrEn}, 0);
        check("rst_rden",  {31'd0, RF_RdEn}, 0);
        check("rst_txvld", {31'd0, TX_D_VLD}, 0);
        check("rst_busy",  {31'd0, BUSY}, 0);
        check("rst_addr",  {28'd0, RF_Address}, 0);
        check("rst_wdata", {24'd0, RF_WrData}, 0);
        check("rst_txdat", {24'd0, TX_P_DATA}, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        cycles(1);
        check("rel_busy", {31'd0, BUSY}, 0);
        check("rel_wren", {31'd0, RF_WrEn}, 0);

        // Write frame, then an immediate second frame
        w0 = wr_cnt;
        send_byte(8'hAA);
        check("wr_busy_addr", {31'd0, BUSY}, 1);
        send_byte(8'h05);
        send_byte(8'h3C);
        check("wr1_en",   {31'd0, RF_WrEn}, 1);
        check("wr1_addr", {28'd0, RF_Address}, 5);
        check("wr1_data", {24'd0, RF_WrData}, 8'h3C);
        check("wr1_busy", {31'd0, BUSY}, 0);
        send_byte(8'hAA);
        check("wr1_pulse_end", {31'd0, RF_WrEn}, 0);
        check("b2b_busy", {31'd0, BUSY}, 1);
        send_byte(8'h16);
        send_byte(8'h11);
        check("wr2_en",   {31'd0, RF_WrEn}, 1);
        check("wr2_addr", {28'd0, RF_Address}, 6);
        check("wr2_data", {24'd0, RF_WrData}, 8'h11);
        cycles(2);
        check("wr_count", wr_cnt - w0, 2);
        check("hold_addr", {28'd0, RF_Address}, 6);
        check("hold_data", {24'd0, RF_WrData}, 8'h11);

        // Read frame after reset
        pulse_reset();
        r0 = rd_cnt; t0 = tx_cnt;
        send_byte(8'hBB);
        send_byte(8'h02);
        check("rd_en",   {31'd0, RF_RdEn}, 1);
        check("rd_addr", {28'd0, RF_Address}, 2);
        check("rd_busy", {31'd0, BUSY}, 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (TX_D_VLD) seen = 1;
        end
        check("rd_tx_seen", {31'd0, seen}, 1);
        check("rd_tx_data", {24'd0, TX_P_DATA}, 8'h81);
        cycles(3);
        check("rd_count", rd_cnt - r0, 1);
        check("rd_tx_count", tx_cnt - t0, 1);
        check("rd_idle", {31'd0, BUSY}, 0);
        check("tx_hold", {24'd0, TX_P_DATA}, 8'h81);

        // Read with TX FIFO full for 10 cycles; a stray byte while waiting is dropped
        t0 = tx_cnt; w0 = wr_cnt;
        FIFO_FULL = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h02);
        cycles(3);
        send_byte(8'hAA);
        cycles(6);
        check("full_no_push", tx_cnt - t0, 0);
        check("full_busy", {31'd0, BUSY}, 1);
        FIFO_FULL = 1'b0;
        cycles(1);
        check("full_push_vld",  {31'd0, TX_D_VLD}, 1);
        check("full_push_data", {24'd0, TX_P_DATA}, 8'h81);
        cycles(1);
        check("full_push_end", {31'd0, TX_D_VLD}, 0);
        check("full_idle", {31'd0, BUSY}, 0);
        check("full_push_cnt", tx_cnt - t0, 1);
        check("full_no_write", wr_cnt - w0, 0);

        // Junk byte ignored, then write addr 1 data 0x7F
        send_byte(8'h55);
        check("junk_busy", {31'd0, BUSY}, 0);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h7F);
        check("wr3_en",   {31'd0, RF_WrEn}, 1);
        check("wr3_addr", {28'd0, RF_Address}, 1);
        check("wr3_data", {24'd0, RF_WrData}, 8'h7F);

        // Read that never returns data times out after 8 waiting cycles
        model_rd_ok = 1'b0;
        t0 = tx_cnt;
        cycles(1);
        send_byte(8'hBB);
        send_byte(8'h03);
        check("to_rd_en", {31'd0, RF_RdEn}, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (!BUSY) break;
            n++;
        end
        check("to_busy_cycles", n, 8);
        cycles(2);
        check("to_no_push", tx_cnt - t0, 0);
        check("to_idle", {31'd0, BUSY}, 0);
        model_rd_ok = 1'b1;

        // Reset in the middle of a write frame
        w0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        #2;
        RST = 1'b0;
        #1;
        check("midrst_busy", {31'd0, BUSY}, 0);
        check("midrst_addr", {28'd0, RF_Address}, 0);
        check("midrst_data", {24'd0, RF_WrData}, 0);
        cycles(2);
        RST = 1'b1;
        cycles(1);
        send_byte(8'h3C);
        check("midrst_discard_busy", {31'd0, BUSY}, 0);
        cycles(3);
        check("midrst_no_write", wr_cnt - w0, 0);
        check("midrst_wdata", {24'd0, RF_WrData}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_cmd_ctrl.md
RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

Interface
REQ-001: Parameter ADDR_SIZE, default 4, register-file address width.
REQ-002: Parameter DATA_WIDTH, default 8, byte/data width.
REQ-003: Parameter RD_TIMEOUT, default 8, max cycles waiting for read-data valid.
REQ-004: CLK  input  1  single clock; all state updates on rising edge.
REQ-005: RST  input  1  reset, asynchronous, active-low.
REQ-006: RX_P_DATA  input  DATA_WIDTH  received byte from UART RX path.
REQ-007: RX_D_VLD  input  1  one-cycle pulse qualifying RX_P_DATA.
REQ-008: RF_WrEn  output  1  register-file write enable.
REQ-009: RF_RdEn  output  1  register-file read enable.
REQ-010: RF_Address  output  ADDR_SIZE  register-file address.
REQ-011: RF_WrData  output  DATA_WIDTH  register-file write data.
REQ-012: RF_RdData  input  DATA_WIDTH  register-file read data.
REQ-013: RF_RdData_valid  input  1  register-file read data valid.
REQ-014: TX_P_DATA  output  DATA_WIDTH  response byte to TX FIFO.
REQ-015: TX_D_VLD  output  1  one-cycle push strobe to TX FIFO.
REQ-016: FIFO_FULL  input  1  TX FIFO full; no push while high.
REQ-017: BUSY  output  1  high in every state except IDLE.

Function
REQ-018: FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND; all outputs registered.
REQ-019: IDLE: RX_D_VLD with 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte discarded, stay IDLE, no output change.
REQ-020: WR_ADDR: on RX_D_VLD latch RX_P_DATA[ADDR_SIZE-1:0] (upper bits ignored) -> WR_DATA.
REQ-021: WR_DATA: on RX_D_VLD drive RF_WrData=byte, RF_Address=latched address, RF_WrEn=1 for exactly the next cycle -> IDLE.
REQ-022: RD_ADDR: on RX_D_VLD drive RF_Address=byte[ADDR_SIZE-1:0], RF_RdEn=1 for exactly the next cycle -> RD_WAIT; clear timeout counter.
REQ-023: RD_WAIT: on RF_RdData_valid capture RF_RdData -> TX_SEND; counter increments each cycle without valid; at RD_TIMEOUT cycles -> IDLE, no TX push.
REQ-024: TX_SEND: when FIFO_FULL=0, TX_P_DATA=captured byte, TX_D_VLD=1 for one cycle -> IDLE; while FIFO_FULL=1 hold state, TX_D_VLD=0.
REQ-025: RX_D_VLD in RD_WAIT or TX_SEND: byte dropped, no state change.
REQ-026: RF_WrEn and RF_RdEn never high in the same cycle; each pulse exactly one cycle.
REQ-027: Back-to-back frames accepted: command byte arriving the cycle after return to IDLE is decoded normally.
REQ-028: RF_Address, RF_WrData, TX_P_DATA hold last value when strobes low.

Reset
REQ-029: RST low asynchronously forces IDLE; RF_WrEn, RF_RdEn, TX_D_VLD, BUSY = 0; RF_Address, RF_WrData, TX_P_DATA, captured data, timeout counter = 0.
REQ-030: Reset mid-frame abandons the frame; no partial write or read is issued after release.

Verification
REQ-031: Reset asserted/released -> all outputs 0, BUSY=0.
REQ-032: Bytes 0xAA,0x05,0x3C -> one-cycle RF_WrEn, RF_Address=5, RF_WrData=0x3C, cycle after third RX_D_VLD; BUSY=0 after.
REQ-033: After reset, bytes 0xBB,0x02 with register file model -> one RF_RdEn pulse addr 2, single TX_D_VLD with TX_P_DATA=0x81.
REQ-034: Read frame with FIFO_FULL=1 for 10 cycles -> no TX_D_VLD during full; single push first cycle after FIFO_FULL=0.
REQ-035: Byte 0x55 then 0xAA,0x01,0x7F -> 0x55 ignored, write addr 1 data 0x7F; read with RF_RdData_valid never asserted -> IDLE after 8 cycles, no push.
REQ-036: 0xAA,0x05, RST pulse, then 0x3C -> no RF_WrEn; 0x3C discarded in IDLE.
